// File: rtl/arbitro_pkg.sv
// Shared definitions for the asteroid-memory arbiter: FSM state codes,
// requester indices and the "no owner" memory-select value.
package arbitro_pkg;

  // FSM state codes; db_arbitro exposes these values directly.
  typedef enum logic [3:0] {
    ST_INICIAL = 4'h0,
    ST_OCIOSO  = 4'h1,
    ST_CONCEDE = 4'h2,
    ST_ATIVO   = 4'h3,
    ST_LIBERA  = 4'h4,
    ST_ERRO    = 4'hF
  } estado_t;

  // Requester indices (bit positions in req/done/grant).
  localparam logic [1:0] REQ_GERA       = 2'd0;
  localparam logic [1:0] REQ_MOVE       = 2'd1;
  localparam logic [1:0] REQ_RENDER     = 2'd2;
  localparam logic [1:0] MEM_SEL_NENHUM = 2'b11;

  // One-hot decode of a requester index; index 3 selects nobody.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      REQ_GERA:   return 3'b001;
      REQ_MOVE:   return 3'b010;
      REQ_RENDER: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Next requester index in the 0 -> 1 -> 2 -> 0 rotation.
  function automatic logic [1:0] proximo(input logic [1:0] idx);
    case (idx)
      REQ_GERA: return REQ_MOVE;
      REQ_MOVE: return REQ_RENDER;
      default:  return REQ_GERA;
    endcase
  endfunction

endpackage

// File: rtl/arbitro_rr_prioridade.sv
// Combinational round-robin priority search over the three requesters.
// The search starts just after the last released owner (ultimo).
module arbitro_rr_prioridade
  import arbitro_pkg::*;
(
  input  logic [2:0] req,
  input  logic [1:0] ultimo,
  output logic [1:0] vencedor,
  output logic       valido
);

  logic [1:0] cand0_s;
  logic [1:0] cand1_s;
  logic [1:0] cand2_s;

  // Candidate order: ultimo+1, ultimo+2, ultimo+3 (mod 3).
  always_comb begin
    cand0_s = proximo(ultimo);
    cand1_s = proximo(cand0_s);
    cand2_s = proximo(cand1_s);
  end

  // First requesting candidate in rotation order wins.
  always_comb begin
    vencedor = REQ_GERA;
    valido   = 1'b0;
    if (|(req & onehot3(cand0_s))) begin
      vencedor = cand0_s;
      valido   = 1'b1;
    end else if (|(req & onehot3(cand1_s))) begin
      vencedor = cand1_s;
      valido   = 1'b1;
    end else if (|(req & onehot3(cand2_s))) begin
      vencedor = cand2_s;
      valido   = 1'b1;
    end else begin
      vencedor = REQ_GERA;
      valido   = 1'b0;
    end
  end

endmodule

// File: rtl/arbitro_mem_asteroide.sv
// Round-robin arbiter for the asteroid memory (generator, mover, renderer).
// Optional watchdog: define ARB_TIMEOUT_EN to revoke a grant held for
// TIMEOUT_CICLOS cycles in ATIVO without a release strobe.
// All outputs are registered from next-state values, so they follow the
// Moore state exactly and clear asynchronously with reset.
module arbitro_mem_asteroide
  import arbitro_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 255
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [2:0] done,
  output logic [2:0] grant,
  output logic [1:0] mem_sel,
  output logic       ocupado,
  output logic       timeout,
  output logic [3:0] db_arbitro
);

  estado_t    state_q,    state_d;
  logic [1:0] vencedor_q, vencedor_d;
  logic [1:0] ultimo_q,   ultimo_d;
  logic [2:0] grant_q,    grant_d;
  logic [1:0] mem_sel_q,  mem_sel_d;
  logic       ocupado_q,  ocupado_d;
  logic [3:0] db_q,       db_d;
  logic       timeout_d;

  logic [1:0] rr_vencedor_s;
  logic       rr_valido_s;
  logic       done_dono_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] LIMITE_CNT = 8'(TIMEOUT_CICLOS - 1);
  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q;
`else
  // Without the watchdog the limit has no effect.
  localparam logic [7:0] LIMITE_CNT = 8'(TIMEOUT_CICLOS - 1);
  logic unused_limite_s;
  assign unused_limite_s = ^LIMITE_CNT;
`endif

  arbitro_rr_prioridade u_rr (
    .req      (req),
    .ultimo   (ultimo_q),
    .vencedor (rr_vencedor_s),
    .valido   (rr_valido_s)
  );

  // Release strobe from the current owner only; other done bits are ignored.
  always_comb begin
    done_dono_s = |(done & onehot3(vencedor_q));
  end

  // Next-state, owner bookkeeping and watchdog counter.
  always_comb begin
    state_d    = state_q;
    vencedor_d = vencedor_q;
    ultimo_d   = ultimo_q;
    timeout_d  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    cnt_d      = cnt_q;
`endif
    case (state_q)
      ST_INICIAL: begin
        state_d = ST_OCIOSO;
      end
      ST_OCIOSO: begin
        if (rr_valido_s) begin
          vencedor_d = rr_vencedor_s;
          state_d    = ST_CONCEDE;
        end else begin
          state_d = ST_OCIOSO;
        end
      end
      ST_CONCEDE: begin
        // done is ignored here; the grant always reaches ATIVO.
        state_d = ST_ATIVO;
`ifdef ARB_TIMEOUT_EN
        cnt_d   = 8'd0;
`endif
      end
      ST_ATIVO: begin
        if (done_dono_s) begin
          // done wins over a simultaneous watchdog expiry.
          state_d = ST_LIBERA;
`ifdef ARB_TIMEOUT_EN
        end else if (cnt_q == LIMITE_CNT) begin
          state_d   = ST_LIBERA;
          timeout_d = 1'b1;
        end else begin
          state_d = ST_ATIVO;
          cnt_d   = cnt_q + 8'd1;
        end
`else
        end else begin
          state_d = ST_ATIVO;
        end
`endif
      end
      ST_LIBERA: begin
        ultimo_d = vencedor_q;
        state_d  = ST_OCIOSO;
      end
      ST_ERRO: begin
        state_d = ST_ERRO;
      end
      default: begin
        // Corrupted state code: park until reset.
        state_d = ST_ERRO;
      end
    endcase
  end

  // Output decode from the next state so registered outputs match the state.
  always_comb begin
    grant_d   = 3'b000;
    mem_sel_d = MEM_SEL_NENHUM;
    ocupado_d = 1'b0;
    db_d      = state_d;
    if ((state_d == ST_CONCEDE) || (state_d == ST_ATIVO)) begin
      grant_d   = onehot3(vencedor_d);
      mem_sel_d = vencedor_d;
      ocupado_d = 1'b1;
    end else begin
      grant_d   = 3'b000;
      mem_sel_d = MEM_SEL_NENHUM;
      ocupado_d = 1'b0;
    end
  end

  // FSM state and owner registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_INICIAL;
      vencedor_q <= REQ_GERA;
      ultimo_q   <= REQ_RENDER;
    end else begin
      state_q    <= state_d;
      vencedor_q <= vencedor_d;
      ultimo_q   <= ultimo_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      grant_q   <= 3'b000;
      mem_sel_q <= MEM_SEL_NENHUM;
      ocupado_q <= 1'b0;
      db_q      <= 4'h0;
    end else begin
      grant_q   <= grant_d;
      mem_sel_q <= mem_sel_d;
      ocupado_q <= ocupado_d;
      db_q      <= db_d;
    end
  end

`ifdef ARB_TIMEOUT_EN
  // Watchdog counter and the one-cycle revoke pulse shown during LIBERA.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = timeout_d;
  assign timeout          = 1'b0;
`endif

  assign grant      = grant_q;
  assign mem_sel    = mem_sel_q;
  assign ocupado    = ocupado_q;
  assign db_arbitro = db_q;

endmodule

// File: tb/tb_arbitro_mem_asteroide.sv
// Self-checking bench for arbitro_mem_asteroide: a cycle table plus
// hand-written sequences for async reset and long holds / watchdog.
module tb_arbitro_mem_asteroide;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] req   = 3'b000;
  logic [2:0] done  = 3'b000;
  logic [2:0] grant;
  logic [1:0] mem_sel;
  logic       ocupado;
  logic       timeout;
  logic [3:0] db_arbitro;

  arbitro_mem_asteroide #(.TIMEOUT_CICLOS(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .req        (req),
    .done       (done),
    .grant      (grant),
    .mem_sel    (mem_sel),
    .ocupado    (ocupado),
    .timeout    (timeout),
    .db_arbitro (db_arbitro)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [2:0] req;
    logic [2:0] done;
    logic [2:0] grant;
    logic [1:0] mem_sel;
    logic       ocupado;
    logic [3:0] db;
  } vetor_t;

  typedef struct {
    logic [2:0] grant;
    logic [1:0] mem_sel;
    logic       ocupado;
    logic       timeout;
    logic [3:0] db;
  } esperado_t;

  esperado_t sb_q[$];
  vetor_t    tab[31];
  int        n_cmp = 0;
  int        n_err = 0;

  task automatic cmp(input string nome, input logic [7:0] real_v, input logic [7:0] esp_v);
    n_cmp++;
    if (real_v !== esp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, real_v, esp_v, $time);
    end
  endtask

  task automatic push_exp(input logic [2:0] g, input logic [1:0] m, input logic o,
                          input logic t, input logic [3:0] d);
    esperado_t e;
    e.grant = g; e.mem_sel = m; e.ocupado = o; e.timeout = t; e.db = d;
    sb_q.push_back(e);
  endtask

  task automatic check_pop(input string nome);
    esperado_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: scoreboard empty", nome);
    end else begin
      e = sb_q.pop_front();
      cmp({nome, ".grant"},   grant,      e.grant);
      cmp({nome, ".mem_sel"}, mem_sel,    e.mem_sel);
      cmp({nome, ".ocupado"}, ocupado,    e.ocupado);
      cmp({nome, ".timeout"}, timeout,    e.timeout);
      cmp({nome, ".db"},      db_arbitro, e.db);
    end
  endtask

  // Drive inputs at the falling edge, check #1 after the next rising edge.
  task automatic passo(input string nome, input logic [2:0] r, input logic [2:0] d,
                       input logic [2:0] g, input logic [1:0] m, input logic o,
                       input logic t, input logic [3:0] st);
    @(negedge clock);
    req  = r;
    done = d;
    push_exp(g, m, o, t, st);
    @(posedge clock);
    #1;
    check_pop(nome);
  endtask

  function automatic vetor_t mk(input logic [2:0] r, input logic [2:0] d, input logic [2:0] g,
                                input logic [1:0] m, input logic o, input logic [3:0] st);
    vetor_t v;
    v.req = r; v.done = d; v.grant = g; v.mem_sel = m; v.ocupado = o; v.db = st;
    return v;
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    // req, done -> grant, mem_sel, ocupado, state after the edge
    tab[0]  = mk(3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[1]  = mk(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 4'h2);
    tab[2]  = mk(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 4'h3);
    tab[3]  = mk(3'b111, 3'b001, 3'b000, 2'd3, 1'b0, 4'h4);
    tab[4]  = mk(3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[5]  = mk(3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 4'h2);
    tab[6]  = mk(3'b111, 3'b010, 3'b010, 2'd1, 1'b1, 4'h3); // done in CONCEDE ignored
    tab[7]  = mk(3'b111, 3'b001, 3'b010, 2'd1, 1'b1, 4'h3); // non-owner done ignored
    tab[8]  = mk(3'b111, 3'b010, 3'b000, 2'd3, 1'b0, 4'h4);
    tab[9]  = mk(3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[10] = mk(3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 4'h2);
    tab[11] = mk(3'b111, 3'b000, 3'b100, 2'd2, 1'b1, 4'h3);
    tab[12] = mk(3'b111, 3'b100, 3'b000, 2'd3, 1'b0, 4'h4);
    tab[13] = mk(3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[14] = mk(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 4'h2);
    tab[15] = mk(3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 4'h3);
    tab[16] = mk(3'b111, 3'b001, 3'b000, 2'd3, 1'b0, 4'h4);
    tab[17] = mk(3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[18] = mk(3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 4'h2);
    tab[19] = mk(3'b111, 3'b000, 3'b010, 2'd1, 1'b1, 4'h3);
    tab[20] = mk(3'b101, 3'b101, 3'b010, 2'd1, 1'b1, 4'h3); // req[1] dropped, foreign done
    tab[21] = mk(3'b101, 3'b000, 3'b010, 2'd1, 1'b1, 4'h3);
    tab[22] = mk(3'b101, 3'b010, 3'b000, 2'd3, 1'b0, 4'h4);
    tab[23] = mk(3'b101, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[24] = mk(3'b101, 3'b000, 3'b100, 2'd2, 1'b1, 4'h2); // search starts at 2
    tab[25] = mk(3'b101, 3'b000, 3'b100, 2'd2, 1'b1, 4'h3);
    tab[26] = mk(3'b101, 3'b100, 3'b000, 2'd3, 1'b0, 4'h4);
    tab[27] = mk(3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1);
    tab[28] = mk(3'b000, 3'b000, 3'b000, 2'd3, 1'b0, 4'h1); // idle with no request
    tab[29] = mk(3'b010, 3'b000, 3'b010, 2'd1, 1'b1, 4'h2);
    tab[30] = mk(3'b010, 3'b000, 3'b010, 2'd1, 1'b1, 4'h3);

    // Reset state while reset is held low.
    repeat (3) @(posedge clock);
    #1;
    push_exp(3'b000, 2'd3, 1'b0, 1'b0, 4'h0);
    check_pop("reset_hold");
    #1;
    reset = 1'b1;

    // Table-driven main sequence.
    for (int i = 0; i < 31; i++) begin
      passo($sformatf("vec%0d", i), tab[i].req, tab[i].done,
            tab[i].grant, tab[i].mem_sel, tab[i].ocupado, 1'b0, tab[i].db);
    end

    // Asynchronous reset mid-ATIVO, between clock edges.
    @(posedge clock);
    #3;
    reset = 1'b0;
    #1;
    push_exp(3'b000, 2'd3, 1'b0, 1'b0, 4'h0);
    check_pop("async_reset");
    @(posedge clock);
    #2;
    reset = 1'b1;
    passo("rst_rel0", 3'b111, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 4'h1);
    passo("rst_rel1", 3'b111, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'h2);
    passo("rst_rel2", 3'b011, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'h3);

`ifdef ARB_TIMEOUT_EN
    // Owner 0 never releases; watchdog limit is 4 ATIVO cycles.
    for (int k = 0; k < 3; k++) begin
      passo($sformatf("wd_hold%0d", k), 3'b011, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'h3);
    end
    passo("wd_libera", 3'b011, 3'b000, 3'b000, 2'd3, 1'b0, 1'b1, 4'h4);
    passo("wd_ocioso", 3'b011, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0, 4'h1);
    passo("wd_next",   3'b011, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'h2);
    passo("wd_ativo",  3'b011, 3'b000, 3'b010, 2'd1, 1'b1, 1'b0, 4'h3);
    passo("wd_done",   3'b011, 3'b010, 3'b000, 2'd3, 1'b0, 1'b0, 4'h4);
`else
    // Long hold without done: grant must never be revoked.
    for (int k = 0; k < 1000; k++) begin
      passo($sformatf("hold%0d", k), 3'b011, 3'b000, 3'b001, 2'd0, 1'b1, 1'b0, 4'h3);
    end
    passo("hold_done", 3'b011, 3'b001, 3'b000, 2'd3, 1'b0, 1'b0, 4'h4);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
